// File: rtl/vga_block_pkg.sv
// Shared screen/block geometry and walker state encoding for block-address users.
package vga_block_pkg;

    localparam int unsigned H_RES      = 640;
    localparam int unsigned V_RES      = 480;
    localparam int unsigned BLOCK_W    = 16;
    localparam int unsigned BLOCK_H    = 16;
    localparam int unsigned COLS       = H_RES / BLOCK_W;
    localparam int unsigned ROWS       = V_RES / BLOCK_H;
    localparam int unsigned NUM_BLOCKS = COLS * ROWS;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned BW_LOG2 = $clog2(BLOCK_W);
    localparam int unsigned BH_LOG2 = $clog2(BLOCK_H);

    // Sized copies so comparisons stay width-matched.
    localparam logic [ADDR_W-1:0]  COLS_A       = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0]  NUM_BLOCKS_A = ADDR_W'(NUM_BLOCKS);
    localparam logic [BW_LOG2-1:0] OX_MAX       = BW_LOG2'(BLOCK_W - 1);
    localparam logic [BH_LOG2-1:0] OY_MAX       = BH_LOG2'(BLOCK_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WALK
    } walker_state_e;

endpackage

// File: rtl/block_addr_divider.sv
// Iterative divide of a block address by COLS: one subtraction per cycle.
// o_done is high for the single cycle in which o_col/o_row hold the quotient result.
module block_addr_divider
    import vga_block_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic               o_done,
    output logic [COORD_W-1:0] o_col,
    output logic [COORD_W-1:0] o_row
);

    logic [ADDR_W-1:0] r_rem;
    logic [ADDR_W-1:0] r_row;
    logic              r_active;
    logic              w_fits;

    assign w_fits = (r_rem < COLS_A);

    // Load on start, then subtract COLS until the remainder fits in one row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_rem    <= i_addr;
            r_row    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (w_fits) begin
                r_active <= 1'b0;
            end else begin
                r_rem <= r_rem - COLS_A;
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign o_done = r_active && w_fits;
    // Remainder < 40 and row < 30 for legal addresses, so the low bits carry the result.
    assign o_col  = r_rem[COORD_W-1:0];
    assign o_row  = r_row[COORD_W-1:0];

endmodule

// File: rtl/block_pixel_walker.sv
// Expands a pixel-block address into the raster-ordered stream of its screen pixels.
module block_pixel_walker
    import vga_block_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               addr_err
);

    walker_state_e r_state;
    walker_state_e w_state_next;

    logic               w_accept;
    logic               w_legal;
    logic               w_start;
    logic               w_fire;
    logic               w_div_done;
    logic [COORD_W-1:0] w_div_col;
    logic [COORD_W-1:0] w_div_row;

    logic [COORD_W-1:0] r_base_x;
    logic [COORD_W-1:0] r_base_y;
    logic [BW_LOG2-1:0] r_ox;
    logic [BH_LOG2-1:0] r_oy;
    logic               r_addr_err;

    assign w_accept = req_valid && req_ready;
    assign w_legal  = (req_addr < NUM_BLOCKS_A);
    assign w_start  = w_accept && w_legal;
    assign w_fire   = pix_valid && pix_ready;

    block_addr_divider u_divider (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_addr  (req_addr),
        .o_done  (w_div_done),
        .o_col   (w_div_col),
        .o_row   (w_div_row)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        pix_valid    = 1'b0;
        busy         = 1'b0;
        pix_last     = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_start) begin
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                busy = 1'b1;
                if (w_div_done) begin
                    w_state_next = WALK;
                end
            end
            WALK: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                pix_last  = (r_ox == OX_MAX) && (r_oy == OY_MAX);
                if (pix_ready && pix_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Rejected addresses raise a one-cycle error pulse; nothing else is started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_accept && !w_legal;
        end
    end

    // Block origin latched at the end of decode; offsets advance once per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base_x <= '0;
            r_base_y <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
        end else if ((r_state == DECODE) && w_div_done) begin
            r_base_x <= w_div_col << BW_LOG2;
            r_base_y <= w_div_row << BH_LOG2;
            r_ox     <= '0;
            r_oy     <= '0;
        end else if (w_fire) begin
            r_ox <= r_ox + 1'b1;
            if (r_ox == OX_MAX) begin
                r_oy <= r_oy + 1'b1;
            end
        end
    end

    assign addr_err = r_addr_err;
    assign pix_x    = r_base_x + COORD_W'(r_ox);
    assign pix_y    = r_base_y + COORD_W'(r_oy);

endmodule

// File: tb/tb_block_pixel_walker.sv
// Self-checking bench for block_pixel_walker: vector table, random blocks, stalls, reset abort.
module tb_block_pixel_walker;

    localparam int COLS_M = 40;
    localparam int NBLK_M = 1200;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [11:0] req_addr;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_last;
    logic       busy;
    logic       addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    block_pixel_walker dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit err;
        int fx;
        int fy;
        int lx;
        int ly;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to completion, checking against the arithmetic model.
    task automatic run_block(input int addr, input bit rand_ready, input int abort_at,
                             output int fx, output int fy, output int lx, output int ly);
        int exp_x[256];
        int exp_y[256];
        int row, col, lat, idx, cyc;
        bit rdy, aborted;
        fx = -1; fy = -1; lx = -1; ly = -1;
        row = addr / COLS_M;
        col = addr % COLS_M;
        for (int i = 0; i < 256; i++) begin
            exp_x[i] = col * 16 + (i % 16);
            exp_y[i] = row * 16 + (i / 16);
        end
        chk("pre_req_ready", int'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = 12'(addr);
        step();
        req_valid = 1'b0;
        req_addr  = 12'($urandom_range(4095));
        if (addr >= NBLK_M) begin
            chk("err_pulse", int'(addr_err), 1);
            chk("err_req_ready", int'(req_ready), 1);
            chk("err_busy", int'(busy), 0);
            for (int k = 0; k < 5; k++) begin
                pix_ready = 1'($urandom_range(1));
                chk("err_pix_valid", int'(pix_valid), 0);
                step();
                chk("err_pulse_clear", int'(addr_err), 0);
                chk("err_req_ready_held", int'(req_ready), 1);
            end
            return;
        end
        chk("acc_addr_err", int'(addr_err), 0);
        chk("acc_busy", int'(busy), 1);
        chk("acc_req_ready", int'(req_ready), 0);
        // Decode wait: pix_ready wiggles here must not matter.
        lat = 1;
        while (!pix_valid && lat < 100) begin
            pix_ready = 1'($urandom_range(1));
            req_valid = 1'($urandom_range(1));
            step();
            lat++;
        end
        req_valid = 1'b0;
        chk("first_latency", lat, 2 + row);
        idx = 0;
        cyc = 0;
        aborted = 1'b0;
        while (idx < 256 && cyc < 5000) begin
            if (idx == abort_at) begin
                rst = 1'b1;
                pix_ready = 1'b1;
                step();
                chk("abort_pix_valid", int'(pix_valid), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_req_ready", int'(req_ready), 1);
                chk("abort_addr_err", int'(addr_err), 0);
                chk("abort_pix_x", int'(pix_x), 0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            rdy = rand_ready ? ($urandom_range(99) < 50) : 1'b1;
            pix_ready = rdy;
            if (!pix_valid) begin
                chk("walk_pix_valid", int'(pix_valid), 1);
                break;
            end
            chk("walk_pix_x", int'(pix_x), exp_x[idx]);
            chk("walk_pix_y", int'(pix_y), exp_y[idx]);
            chk("walk_pix_last", int'(pix_last), (idx == 255) ? 1 : 0);
            chk("walk_req_ready", int'(req_ready), 0);
            chk("walk_block_of_pixel", (int'(pix_y) / 16) * COLS_M + int'(pix_x) / 16, addr);
            if (idx == 0) begin fx = int'(pix_x); fy = int'(pix_y); end
            if (idx == 255) begin lx = int'(pix_x); ly = int'(pix_y); end
            step();
            if (rdy) idx++;
            cyc++;
        end
        pix_ready = 1'b0;
        if (!aborted) begin
            chk("walk_count", idx, 256);
            chk("done_pix_valid", int'(pix_valid), 0);
            chk("done_req_ready", int'(req_ready), 1);
            chk("done_busy", int'(busy), 0);
        end
    endtask

    initial begin
        int fx, fy, lx, ly, a;
        vecs[0] = '{addr: 0,    err: 1'b0, fx: 0,   fy: 0,   lx: 15,  ly: 15};
        vecs[1] = '{addr: 1199, err: 1'b0, fx: 624, fy: 464, lx: 639, ly: 479};
        vecs[2] = '{addr: 41,   err: 1'b0, fx: 16,  fy: 16,  lx: 31,  ly: 31};
        vecs[3] = '{addr: 1200, err: 1'b1, fx: -1,  fy: -1,  lx: -1,  ly: -1};
        vecs[4] = '{addr: 4095, err: 1'b1, fx: -1,  fy: -1,  lx: -1,  ly: -1};
        vecs[5] = '{addr: 39,   err: 1'b0, fx: 624, fy: 0,   lx: 639, ly: 15};
        vecs[6] = '{addr: 40,   err: 1'b0, fx: 0,   fy: 16,  lx: 15,  ly: 31};

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        pix_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr_err", int'(addr_err), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_pix_last", int'(pix_last), 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 7; v++) begin
            run_block(vecs[v].addr, 1'b0, -1, fx, fy, lx, ly);
            chk("vec_first_x", fx, vecs[v].fx);
            chk("vec_first_y", fy, vecs[v].fy);
            chk("vec_last_x", lx, vecs[v].lx);
            chk("vec_last_y", ly, vecs[v].ly);
            step();
        end

        // Back-pressure corner: random stalls on a mid-screen block.
        run_block(77, 1'b1, -1, fx, fy, lx, ly);
        chk("stall_first_x", fx, 592);
        chk("stall_first_y", fy, 16);

        // Random legal and illegal requests with random stalls.
        for (int r = 0; r < 6; r++) begin
            a = (r == 5) ? int'($urandom_range(4095, 1200)) : int'($urandom_range(1199));
            run_block(a, 1'b1, -1, fx, fy, lx, ly);
            step();
        end

        // Reset partway through a block, then a clean follow-up request.
        run_block(5, 1'b0, 99, fx, fy, lx, ly);
        run_block(6, 1'b0, -1, fx, fy, lx, ly);
        chk("post_abort_first_x", fx, 96);
        chk("post_abort_first_y", fy, 0);
        chk("post_abort_last_x", lx, 111);
        chk("post_abort_last_y", ly, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
